// File: rtl/bus_arb_pkg.sv
// Shared definitions for the motherboard bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter state encoding and the width of the optional grant-timeout counter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_OWNED   = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

  localparam int ARB_TOW = 8;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   req_i  active-high request vector
//   ptr_i  index that has priority this round
//   win_o  winning index (0 when nothing requests)
//   any_o  at least one request present
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] win_o,
  output logic            any_o
);

  int              idx;
  logic [IDXW-1:0] idx_l;

  // Scan from ptr_i upwards; any_o doubles as the "already found" flag so the
  // first hit in rotated order wins.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = 0;
    idx_l = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx   = (int'(ptr_i) + i) % NREQ;
      idx_l = IDXW'(idx);
      if (!any_o && req_i[idx_l]) begin
        win_o = idx_l;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Motherboard bus arbiter: 68000 BR/BG/BGACK handshake per local master, round-robin winner choice.
// Latency: BR low in idle -> BG low after 2 clocks; valid BGACK_REQ -> BGACK low after 1 clock.
// Backpressure: a granted owner keeps the bus until it drops BGACK_REQ; no preemption.
//
// Ports:
//   CLKCPU       CPU clock, all logic on posedge
//   RESET        synchronous active-low reset
//   BR[NREQ]     bus request per master, active-low
//   BGACK_REQ    bus-grant-acknowledge per master, active-low
//   AS           motherboard address strobe, active-low, already synchronised
//   BG[NREQ]     bus grant per master, active-low, at most one low
//   BGACK        motherboard BGACK, active-low while a master owns the bus
//   OWNER        index of current owner, meaningful while BUS_OWNED=1
//   BUS_OWNED    a master owns the bus; bridge must release its strobes
//   TIMEOUT_ERR  one-cycle pulse when a grant is never acknowledged
// Build option: define ARB_TIMEOUT_EN to withdraw grants not acknowledged within TIMEOUT cycles.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int TIMEOUT = 64,
  localparam int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            CLKCPU,
  input  logic            RESET,
  input  logic [NREQ-1:0] BR,
  input  logic [NREQ-1:0] BGACK_REQ,
  input  logic            AS,
  output logic [NREQ-1:0] BG,
  output logic            BGACK,
  output logic [IDXW-1:0] OWNER,
  output logic            BUS_OWNED,
  output logic            TIMEOUT_ERR
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [NREQ-1:0] bg_q, bg_d;
  logic            bgack_q, bgack_d;
  logic            owned_q, owned_d;
  logic            err_q, err_d;
  logic [IDXW-1:0] win;
  logic            any_req;
  logic            ack_ok;
  logic            tmo_hit;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i (~BR),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  // An acknowledge only counts once the previous master has finished its cycle.
  assign ack_ok = !BGACK_REQ[owner_q] && AS;

`ifdef ARB_TIMEOUT_EN
  logic [ARB_TOW-1:0] cnt_q, cnt_d;
  // Hit on the TIMEOUT-th grant cycle, so BG rises TIMEOUT clocks after grant.
  assign tmo_hit = (cnt_q == ARB_TOW'(TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^ARB_TOW'(TIMEOUT);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bg_d    = bg_q;
    bgack_d = bgack_q;
    owned_d = owned_q;
    err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (any_req) begin
          owner_d = win;
          bg_d    = ~(NREQ'(1) << win);
          state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A valid acknowledge beats a simultaneous BR release: the master
        // has already taken the bus by the time it lets go of BR.
        if (ack_ok) begin
          bg_d    = '1;
          bgack_d = 1'b0;
          owned_d = 1'b1;
          state_d = ST_OWNED;
        end else if (BR[owner_q]) begin
          bg_d    = '1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          bg_d    = '1;
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d   = cnt_q + ARB_TOW'(1);
`endif
        end
      end
      ST_OWNED: begin
        if (BGACK_REQ[owner_q]) begin
          bgack_d = 1'b1;
          owned_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Priority moves past the master that just finished (or timed out).
        ptr_d   = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      bg_q    <= '1;
      bgack_q <= 1'b1;
      owned_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bg_q    <= bg_d;
      bgack_q <= bgack_d;
      owned_q <= owned_d;
      err_q   <= err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign BG        = bg_q;
  assign BGACK     = bgack_q;
  assign OWNER     = owner_q;
  assign BUS_OWNED = owned_q;
`ifdef ARB_TIMEOUT_EN
  assign TIMEOUT_ERR = err_q;
`else
  assign TIMEOUT_ERR = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter with two masters: directed vector table, hand-written
// corner sequences, then randomized 68000-style masters checked by a
// transaction-level round-robin scoreboard.
module tb_bus_arbiter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] br, ack;
  logic         as_;
  logic [N-1:0] bg;
  logic         bgack, owner, bus_owned, tmo_err;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.NREQ(N), .TIMEOUT(4)) dut (
    .CLKCPU      (clk),
    .RESET       (rst_n),
    .BR          (br),
    .BGACK_REQ   (ack),
    .AS          (as_),
    .BG          (bg),
    .BGACK       (bgack),
    .OWNER       (owner),
    .BUS_OWNED   (bus_owned),
    .TIMEOUT_ERR (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] br;
    logic [N-1:0] ack;
    logic         as_;
    logic [N-1:0] bg;
    logic         bgack;
    logic         owned;
    logic         owner;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] b, input logic [1:0] a, input logic s,
                     input logic [1:0] g, input logic ga, input logic ow, input logic o);
    vec_t v;
    v = '{r, b, a, s, g, ga, ow, o};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Specification rule: first requesting index at or after ptr, wrapping.
  function automatic int rr_model(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // random-phase state
  logic [N-1:0] bg_p, br_l, ack_l;
  logic         bgack_p, as_l;
  int           ptr_m, gowner, grants, zeros, k;
  int           mst_st[N];
  int           hold[N];

  initial begin
    rst_n = 1'b0; br = '1; ack = '1; as_ = 1'b1;

    //        rst br     ack    as  bg     bgack own owner
    add(1'b0, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 0 reset
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 1 idle
    add(1'b1, 2'b10, 2'b11, 1, 2'b11, 1, 0, 0);  // 2 BR0 low -> ARB
    add(1'b1, 2'b10, 2'b11, 1, 2'b10, 1, 0, 0);  // 3 BG0 low
    add(1'b1, 2'b10, 2'b10, 1, 2'b11, 0, 1, 0);  // 4 ack0 -> owned
    add(1'b1, 2'b11, 2'b10, 1, 2'b11, 0, 1, 0);  // 5 BR dropped, still owned
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 6 release
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 7 idle
    add(1'b0, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 8 reset, PTR=0
    add(1'b1, 2'b00, 2'b11, 1, 2'b11, 1, 0, 0);  // 9 both request
    add(1'b1, 2'b00, 2'b11, 1, 2'b10, 1, 0, 0);  // 10 requester 0 wins
    add(1'b1, 2'b00, 2'b10, 1, 2'b11, 0, 1, 0);  // 11 owned by 0
    add(1'b1, 2'b01, 2'b10, 1, 2'b11, 0, 1, 0);  // 12 requester 1 waits
    add(1'b1, 2'b01, 2'b11, 1, 2'b11, 1, 0, 0);  // 13 release, PTR -> 1
    add(1'b1, 2'b01, 2'b11, 1, 2'b11, 1, 0, 0);  // 14 dead cycle
    add(1'b1, 2'b01, 2'b11, 1, 2'b11, 1, 0, 0);  // 15 ARB
    add(1'b1, 2'b01, 2'b11, 1, 2'b01, 1, 0, 0);  // 16 BG1 low
    add(1'b1, 2'b01, 2'b01, 0, 2'b01, 1, 0, 0);  // 17 ack while AS low ignored
    add(1'b1, 2'b01, 2'b01, 0, 2'b01, 1, 0, 0);  // 18 still ignored
    add(1'b1, 2'b01, 2'b01, 1, 2'b11, 0, 1, 1);  // 19 AS high -> owned by 1
    add(1'b1, 2'b11, 2'b01, 1, 2'b11, 0, 1, 1);  // 20 hold
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 21 release, PTR -> 0
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 22 idle
    add(1'b1, 2'b10, 2'b11, 1, 2'b11, 1, 0, 0);  // 23 ARB
    add(1'b1, 2'b10, 2'b11, 1, 2'b10, 1, 0, 0);  // 24 BG0 low
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 25 abort
    add(1'b1, 2'b01, 2'b11, 1, 2'b11, 1, 0, 0);  // 26 ARB
    add(1'b1, 2'b01, 2'b11, 1, 2'b01, 1, 0, 0);  // 27 BG1 low (only requester)
    add(1'b1, 2'b01, 2'b10, 1, 2'b01, 1, 0, 0);  // 28 non-owner ack ignored
    add(1'b1, 2'b01, 2'b00, 1, 2'b11, 0, 1, 1);  // 29 owner acks
    add(1'b0, 2'b01, 2'b00, 1, 2'b11, 1, 0, 0);  // 30 reset while owned
    add(1'b1, 2'b00, 2'b11, 1, 2'b11, 1, 0, 0);  // 31 ARB
    add(1'b1, 2'b00, 2'b11, 1, 2'b10, 1, 0, 0);  // 32 PTR back at 0
    add(1'b1, 2'b11, 2'b11, 1, 2'b11, 1, 0, 0);  // 33 abort

    @(negedge clk);
    // idle after reset for 20 cycles
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("idle%0d bg", c), bg, 2'b11);
      chk($sformatf("idle%0d bgack", c), bgack, 1);
      chk($sformatf("idle%0d owned", c), bus_owned, 0);
    end

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; br = tbl[i].br; ack = tbl[i].ack; as_ = tbl[i].as_;
      step();
      chk($sformatf("row%0d bg", i), bg, tbl[i].bg);
      chk($sformatf("row%0d bgack", i), bgack, tbl[i].bgack);
      chk($sformatf("row%0d owned", i), bus_owned, tbl[i].owned);
      chk($sformatf("row%0d tmo", i), tmo_err, 0);
      if (tbl[i].owned || !tbl[i].rst_n) chk($sformatf("row%0d owner", i), owner, tbl[i].owner);
    end

`ifdef ARB_TIMEOUT_EN
    // grant to requester 1 that never acknowledges
    rst_n = 1'b0; br = '1; ack = '1; as_ = 1'b1;
    step();
    rst_n = 1'b1; br = 2'b01;
    step();
    step();
    chk("tmo grant bg", bg, 2'b01);
    for (int c = 1; c < 4; c++) begin
      step();
      chk($sformatf("tmo wait%0d bg", c), bg, 2'b01);
      chk($sformatf("tmo wait%0d err", c), tmo_err, 0);
    end
    step();
    chk("tmo drop bg", bg, 2'b11);
    chk("tmo pulse", tmo_err, 1);
    chk("tmo bgack", bgack, 1);
    br = 2'b00;
    step();
    chk("tmo pulse end", tmo_err, 0);
    step();
    step();
    chk("tmo ptr past offender", bg, 2'b10);
    br = 2'b11;
    step();
    step();
`endif

    // randomized masters against the round-robin scoreboard
    rst_n = 1'b0; br = '1; ack = '1; as_ = 1'b1;
    step();
    rst_n = 1'b1;
    ptr_m = 0; gowner = 0; grants = 0;
    bg_p = bg; bgack_p = bgack;
    for (int i = 0; i < N; i++) begin mst_st[i] = 0; hold[i] = 0; end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        case (mst_st[i])
          0: begin
            br[i] = 1'b1; ack[i] = 1'b1;
            if ($urandom_range(0, 7) == 0) begin br[i] = 1'b0; mst_st[i] = 1; end
          end
          1: begin
            if (bus_owned && !bgack && int'(owner) == i && !ack[i]) begin
              mst_st[i] = 2; hold[i] = $urandom_range(1, 6);
            end else if (!bg[i]) begin
              if (ack[i] && $urandom_range(0, 2) == 0) ack[i] = 1'b0;
              else if (ack[i] && $urandom_range(0, 29) == 0) begin br[i] = 1'b1; mst_st[i] = 0; end
            end else if (!ack[i]) begin
              ack[i] = 1'b1; br[i] = 1'b1; mst_st[i] = 0;
            end else if ($urandom_range(0, 49) == 0) begin
              br[i] = 1'b1; mst_st[i] = 0;
            end
          end
          default: begin
            br[i] = 1'b1;
            if (hold[i] == 0) begin ack[i] = 1'b1; mst_st[i] = 0; end
            else hold[i]--;
          end
        endcase
      end
      as_ = ($urandom_range(0, 3) != 0);
      br_l = br; ack_l = ack; as_l = as_;
      step();

      zeros = 0;
      for (int j = 0; j < N; j++) if (!bg[j]) zeros++;
      chk("one_bg_low", int'(zeros <= 1), 1);
      chk("owned_vs_bgack", bus_owned, !bgack);
`ifndef ARB_TIMEOUT_EN
      chk("no_tmo", tmo_err, 0);
`endif
      if (bg_p == 2'b11 && bg != 2'b11) begin
        k = bg[0] ? 1 : 0;
        chk("grant_winner", k, rr_model(~br_l, ptr_m));
        chk("grant_while_free", bgack_p, 1);
        gowner = k;
        grants++;
      end else if (bg_p != 2'b11 && bg == 2'b11) begin
        if (!bgack) begin
          chk("ack_valid", int'(!ack_l[gowner] && as_l), 1);
          chk("owner", owner, gowner);
        end else if (tmo_err) begin
          ptr_m = (gowner + 1) % N;
        end else begin
          chk("abort_cause", br_l[gowner], 1);
        end
      end else if (bg_p != 2'b11 && bg == bg_p) begin
        chk("grant_hold", int'((!ack_l[gowner] && as_l) || br_l[gowner]), 0);
      end else if (bg_p != 2'b11) begin
        chk("bg_switch", bg, bg_p);
      end
      if (tmo_err && !(bg_p != 2'b11 && bg == 2'b11)) chk("tmo_at_drop", tmo_err, 0);
      if (bgack_p == 1'b0 && bgack == 1'b1) begin
        chk("release_cause", ack_l[gowner], 1);
        ptr_m = (gowner + 1) % N;
      end
      if (bgack_p == 1'b0 && bgack == 1'b0) chk("own_hold", ack_l[gowner], 0);
      if (bgack_p == 1'b1 && bgack == 1'b0 && bg_p == 2'b11) chk("bgack_no_grant", bgack, 1);
      bg_p = bg; bgack_p = bgack;
    end
    chk("grants_seen", int'(grants > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
